// File: rtl/dtc_pkg.sv
// dtc_pkg: shared definitions for the sequential decision-tree evaluator.
//   - state_e : walker FSM states
//   - node word field offsets / width helpers, parameterised by field widths
//   - node_t  : packed node word at the default widths (12 features, 256 nodes,
//               3-bit classes), handy for building configuration words
package dtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Node word layout, MSB to LSB: {leaf, feat, true_child, false_child, cls}
  function automatic int node_width(input int fidx_w, input int addr_w, input int class_w);
    return 1 + fidx_w + 2 * addr_w + class_w;
  endfunction

  function automatic int cls_lsb();
    return 0;
  endfunction

  function automatic int false_lsb(input int class_w);
    return class_w;
  endfunction

  function automatic int true_lsb(input int addr_w, input int class_w);
    return class_w + addr_w;
  endfunction

  function automatic int feat_lsb(input int addr_w, input int class_w);
    return class_w + 2 * addr_w;
  endfunction

  function automatic int leaf_bit(input int fidx_w, input int addr_w, input int class_w);
    return class_w + 2 * addr_w + fidx_w;
  endfunction

  localparam int DEF_FIDX_W  = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_CLASS_W = 3;

  typedef struct packed {
    logic                   leaf;
    logic [DEF_FIDX_W-1:0]  feat;
    logic [DEF_ADDR_W-1:0]  true_child;
    logic [DEF_ADDR_W-1:0]  false_child;
    logic [DEF_CLASS_W-1:0] cls;
  } node_t;

endpackage

// File: rtl/dtc_node_table.sv
// dtc_node_table: register-based node table for the tree walker.
//   clk   in   clock
//   rst   in   asynchronous active-high reset; every entry becomes RESET_WORD
//   we    in   write strobe
//   waddr in   write index
//   wdata in   write word
//   raddr in   read index
//   rdata out  combinational read of entry raddr
// Entries are plain registers (not block RAM) because reset must initialise
// the whole table and the walker needs a same-cycle read.
module dtc_node_table #(
  parameter int                DEPTH      = 256,
  parameter int                ADDR_W     = 8,
  parameter int                WORD_W     = 24,
  parameter logic [WORD_W-1:0] RESET_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_WORD;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dtc_seq_eval.sv
// dtc_seq_eval: sequential decision-tree classifier. A feature vector is
// latched, then the tree is walked one node per cycle from node 0 until a
// leaf, a bad feature index, or the depth limit ends the walk.
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   in_valid  in   feature vector offered
//   in_ready  out  block idle and accepts a vector
//   inp       in   feature vector (one bit per feature)
//   out_valid out  result held
//   out_ready in   consumer takes result
//   outp      out  class result
//   out_err   out  result is an error (depth limit or bad feature index)
//   cfg_we    in   node table write strobe (honoured only when idle, no accept)
//   cfg_addr  in   node index written
//   cfg_data  in   node word {leaf, feat, true_child, false_child, cls}
//   cfg_busy  out  walker not idle
module dtc_seq_eval
  import dtc_pkg::*;
#(
  parameter int                 N_FEAT        = 12,
  parameter int                 CLASS_W       = 3,
  parameter int                 N_NODES       = 256,
  parameter int                 MAX_DEPTH     = 16,
  parameter logic [CLASS_W-1:0] DEFAULT_CLASS = 3'b111,
  localparam int                ADDR_W        = $clog2(N_NODES),
  localparam int                FIDX_W        = $clog2(N_FEAT),
  localparam int                NODE_W        = node_width(FIDX_W, ADDR_W, CLASS_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_FEAT-1:0]  inp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] outp,
  output logic               out_err,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [NODE_W-1:0]  cfg_data,
  output logic               cfg_busy
);

  localparam int CLS_LSB   = cls_lsb();
  localparam int FALSE_LSB = false_lsb(CLASS_W);
  localparam int TRUE_LSB  = true_lsb(ADDR_W, CLASS_W);
  localparam int FEAT_LSB  = feat_lsb(ADDR_W, CLASS_W);
  localparam int LEAF_BIT  = leaf_bit(FIDX_W, ADDR_W, CLASS_W);
  localparam int STEP_W    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  // Reset image of a node: a leaf returning DEFAULT_CLASS, all else zero.
  localparam logic [NODE_W-1:0] RESET_WORD =
    (NODE_W'(1) << LEAF_BIT) | NODE_W'(DEFAULT_CLASS);

  state_e              state_q;
  logic [N_FEAT-1:0]   inp_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   ptr_d;
  logic [STEP_W-1:0]   step_q;
  logic [CLASS_W-1:0]  outp_q;
  logic                out_err_q;
  logic                out_valid_q;
  logic                in_ready_q;
  logic                busy_q;

  logic [NODE_W-1:0]   node_word;
  logic                node_leaf;
  logic [FIDX_W-1:0]   node_feat;
  logic [ADDR_W-1:0]   node_true;
  logic [ADDR_W-1:0]   node_false;
  logic [CLASS_W-1:0]  node_cls;
  logic                feat_bad;
  logic                depth_hit;
  logic                tbl_we;

  // in_ready_q is high exactly in IDLE, and in IDLE any in_valid is an
  // accept, so a write is only taken when idle with no vector offered. This
  // keeps the walk on the pre-write table when both arrive together.
  assign tbl_we = cfg_we && in_ready_q && !in_valid;

  dtc_node_table #(
    .DEPTH      (N_NODES),
    .ADDR_W     (ADDR_W),
    .WORD_W     (NODE_W),
    .RESET_WORD (RESET_WORD)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (ptr_q),
    .rdata (node_word)
  );

  assign node_leaf  = node_word[LEAF_BIT];
  assign node_feat  = node_word[FEAT_LSB +: FIDX_W];
  assign node_true  = node_word[TRUE_LSB +: ADDR_W];
  assign node_false = node_word[FALSE_LSB +: ADDR_W];
  assign node_cls   = node_word[CLS_LSB +: CLASS_W];

  assign feat_bad  = ({1'b0, node_feat} >= (FIDX_W + 1)'(N_FEAT));
  assign depth_hit = (step_q == STEP_W'(MAX_DEPTH - 1));

  // Feature bit is only consulted when feat_bad is low, so the select is
  // always in range when it matters.
  always_comb begin
    ptr_d = node_false;
    if (!feat_bad && inp_q[node_feat]) begin
      ptr_d = node_true;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      inp_q       <= '0;
      ptr_q       <= '0;
      step_q      <= '0;
      outp_q      <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            inp_q      <= inp;
            ptr_q      <= '0;
            step_q     <= '0;
            state_q    <= ST_WALK;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_WALK: begin
          if (node_leaf) begin
            outp_q      <= node_cls;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (feat_bad || depth_hit) begin
            outp_q      <= DEFAULT_CLASS;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            ptr_q  <= ptr_d;
            step_q <= step_q + STEP_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign outp      = outp_q;
  assign out_err   = out_err_q;
  assign cfg_busy  = busy_q;

endmodule

// File: tb/tb_dtc_seq_eval.sv
// Testbench for dtc_seq_eval: directed cases plus random trees, checked
// against a behavioural tree-walk model held in plain arrays.
module tb_dtc_seq_eval;
  import dtc_pkg::*;

  localparam int MAXD    = 16;
  localparam int DEF_CLS = 7;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] inp;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  outp;
  logic        out_err;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [23:0] cfg_data;
  logic        cfg_busy;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference table
  int m_leaf [256];
  int m_feat [256];
  int m_t    [256];
  int m_f    [256];
  int m_cls  [256];

  dtc_seq_eval dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp      (outp),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_busy  (cfg_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_leaf[i] = 1; m_feat[i] = 0; m_t[i] = 0; m_f[i] = 0; m_cls[i] = DEF_CLS;
    end
  endtask

  // Walk from node 0: result class, error flag and cycles from accept to out_valid.
  task automatic model_walk(input logic [11:0] v, output int cls, output int err, output int lat);
    int p;
    p = 0;
    cls = DEF_CLS; err = 1; lat = MAXD;
    for (int s = 0; s < MAXD; s++) begin
      if (m_leaf[p] != 0) begin
        cls = m_cls[p]; err = 0; lat = s + 1; return;
      end
      if (m_feat[p] >= 12) begin
        cls = DEF_CLS; err = 1; lat = s + 1; return;
      end
      p = v[m_feat[p]] ? m_t[p] : m_f[p];
    end
  endtask

  function automatic logic [23:0] pack_node(input int leaf, input int feat, input int t,
                                            input int f, input int cls);
    node_t nd;
    nd.leaf        = 1'(leaf);
    nd.feat        = 4'(feat);
    nd.true_child  = 8'(t);
    nd.false_child = 8'(f);
    nd.cls         = 3'(cls);
    return nd;
  endfunction

  task automatic cfg_write(input int addr, input int leaf, input int feat, input int t,
                           input int f, input int cls);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = 8'(addr);
    cfg_data = pack_node(leaf, feat, t, f, cls);
    @(negedge clk);
    cfg_we = 1'b0;
    m_leaf[addr] = leaf; m_feat[addr] = feat; m_t[addr] = t; m_f[addr] = f; m_cls[addr] = cls;
  endtask

  // One transaction. acc_we / walk_we attempt a node-0 overwrite (leaf, class 5)
  // on the accept cycle / first walk cycle; both must be dropped.
  task automatic run_vec(input logic [11:0] v, input int hold, input bit acc_we, input bit walk_we);
    int ecls, eerr, elat, k;
    model_walk(v, ecls, eerr, elat);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    inp      = v;
    cfg_we   = acc_we;
    cfg_addr = 8'd0;
    cfg_data = pack_node(1, 0, 0, 0, 5);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    inp      = $urandom_range(0, 4095);
    cfg_we   = walk_we;
    k = 0;
    if (!out_valid) check("busy_walk", 32'(cfg_busy), 32'd1);
    while (!out_valid && k < 64) begin
      @(negedge clk);
      cfg_we = 1'b0;
      k++;
    end
    cfg_we = 1'b0;
    check("latency", 32'(k), 32'(elat));
    check("outp", 32'(outp), 32'(ecls));
    check("out_err", 32'(out_err), 32'(eerr));
    $display("txn inp=%03h outp=%0d err=%0d lat=%0d exp_outp=%0d exp_err=%0d exp_lat=%0d",
             v, outp, out_err, k, ecls, eerr, elat);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_outp", 32'(outp), 32'(ecls));
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_outp", 32'(outp), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; inp = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_outp", 32'(outp), 32'd0);
    check("reset_err", 32'(out_err), 32'd0);
    check("reset_busy", 32'(cfg_busy), 32'd0);

    // Reset-state table: root is a default leaf
    run_vec(12'h000, 0, 1'b0, 1'b0);

    // Two-level tree on feature 9
    cfg_write(0, 0, 9, 2, 1, 0);
    cfg_write(1, 1, 0, 0, 0, 3);
    cfg_write(2, 1, 0, 0, 0, 0);
    run_vec(12'h200, 0, 1'b0, 1'b0);
    run_vec(12'h000, 0, 1'b0, 1'b0);

    // Back-pressure, then back-to-back accept
    run_vec(12'h200, 5, 1'b0, 1'b0);
    run_vec(12'hDFF, 0, 1'b0, 1'b0);

    // Write on the accept cycle is dropped; walk uses the pre-write table
    run_vec(12'h200, 0, 1'b1, 1'b0);
    run_vec(12'h000, 0, 1'b0, 1'b0);

    // Self-loop hits the depth limit
    cfg_write(0, 0, 0, 0, 0, 0);
    run_vec(12'hABC, 1, 1'b0, 1'b0);
    // Write during walk is dropped, confirmed by the next walk
    run_vec(12'h001, 0, 1'b0, 1'b1);
    run_vec(12'h001, 0, 1'b0, 1'b0);

    // Bad feature index
    cfg_write(0, 0, 13, 1, 2, 0);
    run_vec(12'hFFF, 0, 1'b0, 1'b0);

    // Reset mid-walk: self-loop root, reset a few cycles after accept
    cfg_write(0, 0, 3, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b1; inp = 12'h008;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midwalk_busy", 32'(cfg_busy), 32'd1);
    do_reset();
    repeat (3) @(negedge clk);
    check("after_rst_valid", 32'(out_valid), 32'd0);
    run_vec(12'h000, 0, 1'b0, 1'b0);

    // Reset while a result is held drops it immediately
    cfg_write(0, 1, 0, 0, 0, 2);
    @(negedge clk);
    in_valid = 1'b1; inp = 12'h000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("done_valid", 32'(out_valid), 32'd1);
    do_reset();
    run_vec(12'h000, 0, 1'b0, 1'b0);

    // Random trees over nodes 0..15 with random vectors
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 16; a++) begin
        int lf, ft;
        lf = ($urandom_range(0, 2) == 0) ? 1 : 0;
        ft = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11);
        cfg_write(a, lf, ft, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      end
      for (int t = 0; t < 8; t++) begin
        run_vec(12'($urandom_range(0, 4095)), $urandom_range(0, 2),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
